// File: rtl/psw_pkg.sv
// Shared constants, key mapping and repeat-FSM state type for the push-button front end.
package psw_pkg;

    localparam int unsigned N_PSW = 20;
    localparam int unsigned N_HEX = 16;

    localparam int unsigned CLEAR_IDX   = 4;
    localparam int unsigned BUTTON1_IDX = 9;
    localparam int unsigned BUTTON2_IDX = 14;
    localparam int unsigned BUTTON3_IDX = 19;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

    // Hex key k lives at row k/4, col k%4; psw index is 5*row+col.
    function automatic logic [4:0] hex_to_psw(input logic [3:0] k);
        return 5'(k[3:2]) * 5'd5 + 5'(k[1:0]);
    endfunction

endpackage

// File: rtl/psw_debounce_cell.sv
// One button: two-flop synchronizer, stable-sample debounce counter and edge pulses.
module psw_debounce_cell #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic release_o
);

    localparam int unsigned CntW = $clog2(DB_CYCLES);

    logic            s1_q, s2_q, level_q, press_q, release_q;
    logic [CntW-1:0] cnt_q;
    logic            toggle;

    assign toggle = (s2_q != level_q) && (cnt_q == CntW'(DB_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            level_q   <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
            // Any sample matching the current level restarts the count.
            if ((s2_q == level_q) || toggle) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
            if (toggle) begin
                level_q <= ~level_q;
            end
            press_q   <= toggle & ~level_q;
            release_q <= toggle & level_q;
        end
    end

    assign level     = level_q;
    assign press     = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/psw_debouncer.sv
// Debounced levels/pulses for all twenty buttons plus hex-key event encoder with auto-repeat.
module psw_debouncer
    import psw_pkg::*;
#(
    parameter int unsigned DB_CYCLES    = 16,
    parameter int unsigned REPEAT_DELAY = 4096,
    parameter int unsigned REPEAT_RATE  = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_PSW-1:0] psw,
    input  logic             repeat_en,
    output logic [N_PSW-1:0] level,
    output logic [N_PSW-1:0] press,
    output logic [N_PSW-1:0] release_o,
    output logic             key_in,
    output logic [3:0]       key_val,
    output logic             multi
);

    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RptW   = $clog2(RptMax);

    for (genvar i = 0; i < N_PSW; i++) begin : g_cell
        psw_debounce_cell #(
            .DB_CYCLES(DB_CYCLES)
        ) u_cell (
            .clock    (clock),
            .reset    (reset),
            .raw      (psw[i]),
            .level    (level[i]),
            .press    (press[i]),
            .release_o(release_o[i])
        );
    end

    logic [N_HEX-1:0] hex_level, hex_press;

    for (genvar k = 0; k < N_HEX; k++) begin : g_hex
        assign hex_level[k] = level[hex_to_psw(4'(k))];
        assign hex_press[k] = press[hex_to_psw(4'(k))];
    end

    logic       press_any;
    logic [3:0] press_key;
    logic [4:0] hex_count;

    always_comb begin
        press_any = |hex_press;
        press_key = '0;
        for (int i = N_HEX - 1; i >= 0; i--) begin
            if (hex_press[i]) press_key = 4'(i);
        end
        hex_count = '0;
        for (int i = 0; i < N_HEX; i++) begin
            hex_count = hex_count + 5'(hex_level[i]);
        end
    end

    rpt_state_t      state_q, state_d;
    logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [3:0]      latch_q, latch_d;
    logic            key_in_q, key_in_d;
    logic [3:0]      key_val_q, key_val_d;
    logic            multi_q;
    logic            rpt_fire, single, many;

    assign single = repeat_en && (hex_count == 5'd1);
    assign many   = hex_count > 5'd1;

    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        latch_d   = latch_q;
        rpt_fire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_any && single) begin
                    state_d   = DELAY;
                    rpt_cnt_d = RptW'(REPEAT_DELAY - 1);
                    latch_d   = press_key;
                end
            end
            DELAY, REPEAT: begin
                // A fresh press takes priority over both abort and a due repeat.
                if (press_any) begin
                    if (single) begin
                        state_d   = DELAY;
                        rpt_cnt_d = RptW'(REPEAT_DELAY - 1);
                        latch_d   = press_key;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!hex_level[latch_q] || many || !repeat_en) begin
                    state_d = IDLE;
                end else if (rpt_cnt_q == '0) begin
                    rpt_fire  = 1'b1;
                    state_d   = REPEAT;
                    rpt_cnt_d = RptW'(REPEAT_RATE - 1);
                end else begin
                    rpt_cnt_d = rpt_cnt_q - RptW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        key_in_d  = press_any | rpt_fire;
        key_val_d = key_val_q;
        if (press_any) begin
            key_val_d = press_key;
        end else if (rpt_fire) begin
            key_val_d = latch_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            rpt_cnt_q <= '0;
            latch_q   <= '0;
            key_in_q  <= 1'b0;
            key_val_q <= '0;
            multi_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
            latch_q   <= latch_d;
            key_in_q  <= key_in_d;
            key_val_q <= key_val_d;
            multi_q   <= many;
        end
    end

    assign key_in  = key_in_q;
    assign key_val = key_val_q;
    assign multi   = multi_q;

endmodule
